// File: rtl/fetch_dispatch_pkg.sv
// rtl/fetch_dispatch_pkg.sv - shared encodings and opcode decode for the fetch/dispatch sequencer
package fetch_dispatch_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DECODE,
      ST_EXEC,
      ST_FLUSH,
      ST_HALT,
      ST_ERROR
   } state_t;

   localparam int UNIT_W = 3;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_ADDI = 4'h1;
   localparam logic [3:0] OP_SUBI = 4'h2;
   localparam logic [3:0] OP_ADD  = 4'h3;
   localparam logic [3:0] OP_SUB  = 4'h4;
   localparam logic [3:0] OP_MOV  = 4'h5;
   localparam logic [3:0] OP_LD   = 4'h6;
   localparam logic [3:0] OP_ST   = 4'h7;
   localparam logic [3:0] OP_JMP  = 4'h8;
   localparam logic [3:0] OP_HALT = 4'hF;

   localparam logic [UNIT_W-1:0] UNIT_ALUI = 3'd0;
   localparam logic [UNIT_W-1:0] UNIT_ALU  = 3'd1;
   localparam logic [UNIT_W-1:0] UNIT_MOV  = 3'd2;
   localparam logic [UNIT_W-1:0] UNIT_LDST = 3'd3;
   localparam logic [UNIT_W-1:0] UNIT_JMP  = 3'd4;

   typedef struct packed {
      logic              valid;
      logic [UNIT_W-1:0] unit;
   } unit_map_t;

   // NOP and HALT are handled by the sequencer itself, so they map to no unit.
   function automatic unit_map_t map_opcode(input logic [3:0] op);
      unit_map_t m;
      m.valid = 1'b1;
      m.unit  = UNIT_ALUI;
      case (op)
         OP_ADDI, OP_SUBI: m.unit = UNIT_ALUI;
         OP_ADD, OP_SUB:   m.unit = UNIT_ALU;
         OP_MOV:           m.unit = UNIT_MOV;
         OP_LD, OP_ST:     m.unit = UNIT_LDST;
         OP_JMP:           m.unit = UNIT_JMP;
         default:          m.valid = 1'b0;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/fetch_dispatch_ctrl_watchdog.sv
// rtl/fetch_dispatch_ctrl_watchdog.sv - EXEC cycle counter that flags a unit that never answers
module fetch_watchdog #(
   parameter int TIMEOUT = 32
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT);

   logic [CW-1:0] count;

   // Saturates at the terminal value so a stalled abort cannot wrap back to zero.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count <= '0;
      end else if (en && !expired) begin
         count <= count + 1'b1;
      end
   end

   assign expired = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/fetch_dispatch_ctrl.sv
// rtl/fetch_dispatch_ctrl.sv - fetches, decodes and dispatches instructions to the execution FSMs
module fetch_dispatch_ctrl
   import fetch_dispatch_pkg::*;
#(
   parameter int NUM_UNITS = 5,
   parameter int TIMEOUT   = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 run,
   input  logic [15:0]          mem_data,
   input  logic                 mem_ready,
   input  logic [NUM_UNITS-1:0] done_vec,
   output logic                 pc_out_en,
   output logic                 mem_rd,
   output logic [15:0]          instruction,
   output logic                 pc_inc,
   output logic                 busy,
   output logic                 halted,
   output logic                 illegal,
   output logic                 timeout,
   output logic [15:0]          retired
);

   state_t            state, state_n;
   logic [15:0]       ir, ir_n;
   logic [UNIT_W-1:0] unit_sel, unit_sel_n;
   logic [15:0]       retired_n;
   logic              illegal_n, timeout_n;
   logic              done_hit;
   logic              wd_expired;
   logic              wd_clr, wd_en;
   unit_map_t         dec;

   assign dec    = map_opcode(ir[15:12]);
   assign wd_en  = (state == ST_EXEC);
   assign wd_clr = (state != ST_EXEC);

   fetch_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
      .clk     (clk),
      .rst     (rst),
      .clr     (wd_clr),
      .en      (wd_en),
      .expired (wd_expired)
   );

   // Only the selected unit's done counts; stray pulses from other units are ignored.
   always_comb begin
      done_hit = 1'b0;
      for (int i = 0; i < NUM_UNITS; i++) begin
         if (unit_sel == UNIT_W'(i) && done_vec[i]) begin
            done_hit = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n    = state;
      ir_n       = ir;
      unit_sel_n = unit_sel;
      retired_n  = retired;
      illegal_n  = illegal;
      timeout_n  = timeout;
      case (state)
         ST_IDLE: begin
            if (run) state_n = ST_FETCH;
         end
         ST_FETCH: begin
            if (mem_ready) begin
               ir_n    = mem_data;
               state_n = ST_DECODE;
            end
         end
         ST_DECODE: begin
            if (ir[15:12] == OP_NOP) begin
               retired_n = retired + 16'd1;
               state_n   = ST_FLUSH;
            end else if (ir[15:12] == OP_HALT) begin
               state_n = ST_HALT;
            end else if (dec.valid) begin
               unit_sel_n = dec.unit;
               state_n    = ST_EXEC;
            end else begin
               illegal_n = 1'b1;
               state_n   = ST_ERROR;
            end
         end
         ST_EXEC: begin
            // done is checked first so a completion on the last allowed cycle still retires
            if (done_hit) begin
               retired_n = retired + 16'd1;
               state_n   = ST_FLUSH;
            end else if (wd_expired) begin
               timeout_n = 1'b1;
               state_n   = ST_ERROR;
            end
         end
         ST_FLUSH: begin
            state_n = run ? ST_FETCH : ST_IDLE;
         end
         ST_HALT:  state_n = ST_HALT;
         ST_ERROR: state_n = ST_ERROR;
         default:  state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ir       <= '0;
         unit_sel <= '0;
         retired  <= '0;
         illegal  <= 1'b0;
         timeout  <= 1'b0;
      end else begin
         ir       <= ir_n;
         unit_sel <= unit_sel_n;
         retired  <= retired_n;
         illegal  <= illegal_n;
         timeout  <= timeout_n;
      end
   end

   // Outputs are registered from the next state so they line up with the state they describe.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_out_en   <= 1'b0;
         mem_rd      <= 1'b0;
         instruction <= '0;
         pc_inc      <= 1'b0;
         busy        <= 1'b0;
         halted      <= 1'b0;
      end else begin
         pc_out_en   <= (state_n == ST_FETCH);
         mem_rd      <= (state_n == ST_FETCH);
         instruction <= (state_n == ST_EXEC) ? ir_n : 16'h0000;
         pc_inc      <= (state_n == ST_DECODE) && (ir_n[15:12] == OP_NOP);
         busy        <= !(state_n inside {ST_IDLE, ST_HALT, ST_ERROR});
         halted      <= (state_n == ST_HALT);
      end
   end

endmodule
